// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   SSEG_TABLE   : hex digit -> active-low cathodes {a,b,c,d,e,f,g}
//   SSEG_BLANK   : all cathodes off
//   scan_state_e : per-slot phase, BLANK (guard interval) or DRIVE
package sseg_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'b1111111;

  localparam logic [6:0] SSEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low cathodes {a,b,c,d,e,f,g}
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SSEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS digits on one
// segment bus. Each digit owns a slot of REFRESH_DIV cycles: GUARD dark
// cycles (anti-ghosting), then driven. Display data is double buffered so
// a frame never mixes old and new values.
//   CLK, RST   : clock, asynchronous active-high reset
//   data       : nibble i drives digit i (digit 0 rightmost)
//   dp_in      : decimal point request per digit, active-high
//   digit_en   : per-digit enable, 0 keeps that anode off
//   load       : single-cycle strobe; data/dp_in go to the shadow buffer on
//                any edge where load is high (no handshake, never stalls)
//   seg, dp    : active-low cathodes, registered
//   an         : active-low anodes, one low or all high, registered
//   frame_sync : one-cycle pulse after the active buffer is refreshed
// Debug visibility: state_q, cnt_q and idx_q are plain flops for probing.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_sync
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  scan_state_e             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_sync_q, frame_sync_d;

  logic                    slot_wrap, frame_wrap;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_en, cur_sup, lit;
  logic [6:0]              dec_seg;

  // Counter, digit index, FSM and buffers.
  always_comb begin
    slot_wrap  = (cnt_q == CNT_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // State tracks the region of the next counter value, so it lines up
    // with cnt_q: BLANK while cnt_q < GUARD, DRIVE afterwards.
    state_d      = (cnt_d < GUARD_CNT) ? BLANK : DRIVE;
    shadow_d     = load ? data  : shadow_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    // shadow_d already carries a coincident load, so the new data goes
    // straight to the active buffer on the frame-wrap edge.
    active_d     = frame_wrap ? shadow_d    : active_q;
    active_dp_d  = frame_wrap ? shadow_dp_d : active_dp_q;
    frame_sync_d = frame_wrap;
  end

  // Leading-zero suppression, scanned from the most significant digit down.
  always_comb begin
    zero_run = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_q[4*i +: 4] == 4'h0);
      if ((BLANK_LEADING != 0) && (i > 0) && zero_run && !active_dp_q[i]) begin
        suppress[i] = 1'b1;
      end
    end
  end

  // Select the digit being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = active_q[4*i +: 4];
        cur_dp  = active_dp_q[i];
        cur_en  = digit_en[i];
        cur_sup = suppress[i];
      end
    end
  end

  hex_to_sseg u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Next output values, computed from pre-edge state.
  always_comb begin
    lit   = (state_q == DRIVE) && cur_en && !cur_sup;
    an_d  = '1;
    seg_d = SSEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IDX_W'(i));
      end
      seg_d = dec_seg;
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      an_q         <= '1;
      seg_q        <= SSEG_BLANK;
      dp_q         <= 1'b1;
      frame_sync_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised, time-multiplexed seven-segment display driver. It generalises the single-digit hex decoder with its fixed anode to NUM_DIGITS digits sharing one segment bus. Features: a refresh scan counter, double-buffered display data, leading-zero blanking, per-digit decimal point and enable, and an anti-ghosting guard interval. It sits between the datapath or I/O registers and the board's anode and cathode pins.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be > GUARD.
- GUARD, 1000: blank cycles at the start of each slot (anti-ghosting); 0 disables.
- BLANK_LEADING, 1: 1 enables leading-zero suppression.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- data  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant and rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 holds that anode off.
- load  in  1  captures data/dp_in into the shadow register on this edge.
- seg  out  7  cathodes {a,b,c,d,e,f,g}, active-low, registered.
- dp  out  1  decimal point cathode, active-low, registered.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low or all-high, registered.
- frame_sync  out  1  one-cycle pulse: the active buffer was just refreshed (start of digit 0 slot).

## Operation
- Reset values:
  - an all 1, seg 7'b1111111, dp 1, frame_sync 0.
  - cnt 0, idx 0, state BLANK.
  - shadow and active buffers 0.
- Slot counter cnt counts 0..REFRESH_DIV-1 and wraps. idx advances on wrap; NUM_DIGITS-1 wraps to 0.
- FSM states:
  - BLANK: cnt < GUARD.
  - DRIVE: GUARD ≤ cnt ≤ REFRESH_DIV-1.
  - BLANK→DRIVE when cnt reaches GUARD. DRIVE→BLANK on slot wrap.
  - With GUARD=0, BLANK is never entered after reset.
- Double buffering:
  - load writes shadow.
  - active ← shadow on the frame-wrap edge (cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1).
  - If load coincides with the frame-wrap edge, active takes the incoming data/dp_in directly; shadow takes it too.
  - A frame never mixes old and new data.
- Decode: hex 0–F to active-low segments. Examples: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 7=0001111, F=0111000.
- Leading-zero blank, when BLANK_LEADING=1: digit i>0 is suppressed (an bit held 1) if nibble i and every more significant nibble are 0 and dp bit i is 0. Digit 0 is never suppressed.
- Output registers in DRIVE, with digit idx enabled and not suppressed:
  - an = ~(1<<idx).
  - seg = decode(active nibble idx).
  - dp = ~active_dp[idx].
- In all other cases (BLANK, disabled or suppressed digit): an all 1, seg 7'b1111111, dp 1.

## Timing
- Outputs are registered from pre-edge cnt/state/idx/active, so they lag the counter by one cycle.
- Slot i: GUARD cycles dark, then REFRESH_DIV-GUARD cycles driven. Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- After RST deasserts, the first driven output appears on edge GUARD+1, using active=0.
- load → shadow: 1 cycle. load → visible: at the next frame wrap; worst case NUM_DIGITS*REFRESH_DIV cycles.
- frame_sync goes high the cycle after each frame-wrap edge, for exactly 1 cycle. It never asserts during reset.
- RST asserted mid-slot forces all outputs and state to reset values immediately, without waiting for CLK.

## Structure
- Package sseg_pkg holds:
  - SSEG_TABLE, a 16-entry active-low segment constant;
  - SSEG_BLANK = 7'b1111111;
  - the FSM state enum {BLANK, DRIVE}.
- One combinational sub-module, hex_to_sseg: 4-bit nibble in, 7-bit seg out, indexing SSEG_TABLE.
- Top level holds the counter, FSM, buffers, suppression logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1.
- Reset: RST held 5 cycles, then released → an=1111, seg=1111111, dp=1, frame_sync=0 through edge 1. First drive at edge 2: an=1110, seg=0000001.
- Normal scan: load data=16'h1234, dp_in=0, digit_en=1111. After frame_sync, each slot shows 1 dark cycle, then 3 driven:
  - an=1110, seg=1001100;
  - an=1101, seg=0000110;
  - an=1011, seg=0010010;
  - an=0111, seg=1001111.
- Leading zeros: data=16'h0070, dp_in=0 → digits 3 and 2 stay dark, digit 1 seg=0001111, digit 0 seg=0000001. Then set dp_in=0100 → digit 2 shows 0000001 with dp=0.
- Mid-frame load: active=16'h1234; load 16'hFFFF during the digit-1 slot → digits 2 and 3 still show 2 and 1. After the next frame_sync, all digits show 0111000.
- Load on the wrap edge: load 16'h5555 on the exact frame-wrap edge → the digit-0 slot immediately following shows 5 (0100100). digit_en=1101 keeps an[1] at 1 for the whole frame.
- Async reset mid-slot: RST during the an=1011 slot → an=1111 before the next CLK edge. After release, the scan restarts at digit 0 showing 0, and digits 3..1 are suppressed.
